// File: rtl/cart_mem_arbiter_pkg.sv
// Shared definitions for the cartridge memory arbiter.
//   - default unified-space base addresses of the PRG ROM, CHR and PRG RAM windows
//   - arbiter FSM state encoding
//   - client identifiers used by the round-robin grant logic
package cart_mem_arbiter_pkg;

   localparam logic [19:0] PRG_ROM_BASE_DEF = 20'h00000;
   localparam logic [19:0] CHR_BASE_DEF     = 20'h80000;
   localparam logic [19:0] PRG_RAM_BASE_DEF = 20'hC0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      CLIENT_PRG = 1'b0,
      CLIENT_CHR = 1'b1
   } client_t;

endpackage

// File: rtl/cart_mem_rr_arbiter.sv
// Two-way round-robin grant between the PRG (CPU) and CHR (PPU) clients.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_prg      PRG client request
//   req_chr      CHR client request
//   update       load last_grant with owner (one cycle per finished transaction)
//   owner        client that just finished
//   grant_valid  at least one request present
//   grant        selected client; on a tie, the client that did not finish last
module cart_mem_rr_arbiter
   import cart_mem_arbiter_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    req_prg,
   input  logic    req_chr,
   input  logic    update,
   input  client_t owner,
   output logic    grant_valid,
   output client_t grant
);

   client_t last_grant;

   // Reset to PRG so that CHR wins the very first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= CLIENT_PRG;
      end else if (update) begin
         last_grant <= owner;
      end
   end

   always_comb begin
      grant_valid = req_prg | req_chr;
      grant       = CLIENT_PRG;
      if (req_prg && req_chr) begin
         grant = (last_grant == CLIENT_PRG) ? CLIENT_CHR : CLIENT_PRG;
      end else if (req_chr) begin
         grant = CLIENT_CHR;
      end
   end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Cartridge memory arbiter: maps mapper PRG ROM / PRG RAM / CHR addresses into
// one 20-bit unified byte space and serves the CPU-side (PRG) and PPU-side (CHR)
// clients over a single shared, variable-latency memory port.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   prg_req_i .. prg_wdata_i       PRG client request, region select, address, data
//   prg_ack_o, prg_rdata_o         PRG one-cycle ack and held read data
//   chr_req_i .. chr_wdata_i       CHR client request, address, data
//   chr_ack_o, chr_rdata_o         CHR one-cycle ack and held read data
//   mem_req_o .. mem_wdata_o       shared memory request (held until mem_ack_i)
//   mem_ack_i, mem_rdata_i         memory completion and read data
// Writes to PRG ROM, and to CHR when CHR_WRITABLE = 0, are acknowledged
// without touching memory.
module cart_mem_arbiter
   import cart_mem_arbiter_pkg::*;
#(
   parameter logic [19:0] PRG_ROM_BASE = PRG_ROM_BASE_DEF,
   parameter logic [19:0] CHR_BASE     = CHR_BASE_DEF,
   parameter logic [19:0] PRG_RAM_BASE = PRG_RAM_BASE_DEF,
   parameter bit          CHR_WRITABLE = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        prg_req_i,
   input  logic        prg_sel_ram_i,
   input  logic        prg_we_i,
   input  logic [18:0] prg_rom_addr_i,
   input  logic [14:0] prg_ram_addr_i,
   input  logic [7:0]  prg_wdata_i,
   output logic        prg_ack_o,
   output logic [7:0]  prg_rdata_o,
   input  logic        chr_req_i,
   input  logic        chr_we_i,
   input  logic [17:0] chr_addr_i,
   input  logic [7:0]  chr_wdata_i,
   output logic        chr_ack_o,
   output logic [7:0]  chr_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [19:0] mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [7:0]  mem_rdata_i
);

   state_t      state, state_nxt;
   client_t     owner;
   logic        we_q;
   logic [19:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  prg_rdata_q, chr_rdata_q;

   logic        grant_valid;
   client_t     grant;
   logic [19:0] grant_addr;
   logic        grant_we;
   logic [7:0]  grant_wdata;
   logic        grant_drop;

   cart_mem_rr_arbiter u_rr (
      .clk         (clk_i),
      .rst_n       (rst_n_i),
      .req_prg     (prg_req_i),
      .req_chr     (chr_req_i),
      .update      (state == ST_RESP),
      .owner       (owner),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Unified address and write attributes of the client that would be granted.
   always_comb begin
      grant_addr  = '0;
      grant_we    = 1'b0;
      grant_wdata = '0;
      grant_drop  = 1'b0;
      if (grant == CLIENT_CHR) begin
         grant_addr  = CHR_BASE + {2'b00, chr_addr_i};
         grant_we    = chr_we_i;
         grant_wdata = chr_wdata_i;
         grant_drop  = chr_we_i & ~CHR_WRITABLE;
      end else begin
         grant_addr  = prg_sel_ram_i ? (PRG_RAM_BASE + {5'b00000, prg_ram_addr_i})
                                     : (PRG_ROM_BASE + {1'b0, prg_rom_addr_i});
         grant_we    = prg_we_i;
         grant_wdata = prg_wdata_i;
         grant_drop  = prg_we_i & ~prg_sel_ram_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_req_o = 1'b0;
      prg_ack_o = 1'b0;
      chr_ack_o = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_valid) begin
               state_nxt = grant_drop ? ST_RESP : ST_MEM;
            end
         end
         ST_MEM: begin
            mem_req_o = 1'b1;
            if (mem_ack_i) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            prg_ack_o = (owner == CLIENT_PRG);
            chr_ack_o = (owner == CLIENT_CHR);
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Read data goes straight into the owner's rdata register on mem_ack_i so
   // that it is already valid during the ack cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         owner       <= CLIENT_PRG;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         prg_rdata_q <= '0;
         chr_rdata_q <= '0;
      end else begin
         if (state == ST_IDLE && grant_valid) begin
            owner   <= grant;
            we_q    <= grant_we;
            addr_q  <= grant_addr;
            wdata_q <= grant_wdata;
         end
         if (state == ST_MEM && mem_ack_i && !we_q) begin
            if (owner == CLIENT_CHR) begin
               chr_rdata_q <= mem_rdata_i;
            end else begin
               prg_rdata_q <= mem_rdata_i;
            end
         end
      end
   end

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign prg_rdata_o = prg_rdata_q;
   assign chr_rdata_o = chr_rdata_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic from both clients against a
// transaction-level reference model and a randomly-delayed memory responder.
module tb_cart_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prg_req_i = 1'b0, prg_sel_ram_i = 1'b0, prg_we_i = 1'b0;
   logic [18:0] prg_rom_addr_i = '0;
   logic [14:0] prg_ram_addr_i = '0;
   logic [7:0]  prg_wdata_i = '0;
   logic        prg_ack_o;
   logic [7:0]  prg_rdata_o;
   logic        chr_req_i = 1'b0, chr_we_i = 1'b0;
   logic [17:0] chr_addr_i = '0;
   logic [7:0]  chr_wdata_i = '0;
   logic        chr_ack_o;
   logic [7:0]  chr_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [19:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [7:0]  mem_rdata_i = '0;

   cart_mem_arbiter #(
      .PRG_ROM_BASE (20'h00000),
      .CHR_BASE     (20'h80000),
      .PRG_RAM_BASE (20'hC0000),
      .CHR_WRITABLE (1'b0)
   ) dut (
      .clk_i (clk), .rst_n_i (rst_n),
      .prg_req_i (prg_req_i), .prg_sel_ram_i (prg_sel_ram_i), .prg_we_i (prg_we_i),
      .prg_rom_addr_i (prg_rom_addr_i), .prg_ram_addr_i (prg_ram_addr_i),
      .prg_wdata_i (prg_wdata_i), .prg_ack_o (prg_ack_o), .prg_rdata_o (prg_rdata_o),
      .chr_req_i (chr_req_i), .chr_we_i (chr_we_i), .chr_addr_i (chr_addr_i),
      .chr_wdata_i (chr_wdata_i), .chr_ack_o (chr_ack_o), .chr_rdata_o (chr_rdata_o),
      .mem_req_o (mem_req_o), .mem_we_o (mem_we_o), .mem_addr_o (mem_addr_o),
      .mem_wdata_o (mem_wdata_o), .mem_ack_i (mem_ack_i), .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      bit          sel_ram;
      logic [18:0] addr;
      logic [7:0]  wdata;
      int          gap;
   } op_t;

   int n_cmp = 0, n_fail = 0, cyc = 0;

   op_t q_prg[$], q_chr[$];
   op_t cur_prg, cur_chr;
   bit  prg_active = 0, chr_active = 0;
   int  prg_wait = 0, chr_wait = 0;

   logic [7:0] tb_mem [int];
   logic [7:0] ref_mem [int];
   int  mem_cnt = 0, mem_lat = 0, fixed_lat = 0;
   bit  lat_random = 0, spurious_en = 0;

   // Reference model: the transaction in flight and the expected outputs.
   bit          m_in_mem, m_ack_now, m_owner, m_last, m_we;
   logic [19:0] m_addr;
   logic [7:0]  m_wdata, e_prg_rdata, e_chr_rdata;

   // Observations used by the directed literal checks.
   logic [19:0] obs_addr;
   bit          obs_we, obs_prev_req;
   logic [7:0]  obs_wdata;
   int          memreq_cycles, prg_acks, chr_acks;
   int          prg_ack_cyc, chr_ack_cyc, prg_raise_cyc, chr_raise_cyc;
   bit          ack_log[$];
   bit          exp4 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] dflt(input int a);
      return 8'((a * 37) ^ (a >> 9) ^ 32'h5A);
   endfunction

   function automatic logic [7:0] tb_rd(input int a);
      if (tb_mem.exists(a)) return tb_mem[a];
      return dflt(a);
   endfunction

   function automatic logic [7:0] ref_rd(input int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return dflt(a);
   endfunction

   function automatic logic [19:0] exp_addr(input bit is_chr, input op_t o);
      int unsigned a;
      if (is_chr)         a = 32'h80000 + 32'(o.addr[17:0]);
      else if (o.sel_ram) a = 32'hC0000 + 32'(o.addr[14:0]);
      else                a = 32'(o.addr);
      a = a % 32'h100000;
      return a[19:0];
   endfunction

   function automatic op_t mk_op(input bit we, input bit sel_ram, input logic [18:0] addr,
                                 input logic [7:0] wdata, input int gap);
      op_t o;
      o.we = we; o.sel_ram = sel_ram; o.addr = addr; o.wdata = wdata; o.gap = gap;
      return o;
   endfunction

   task automatic model_reset();
      m_in_mem = 0; m_ack_now = 0; m_owner = 0; m_last = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; e_prg_rdata = '0; e_chr_rdata = '0;
   endtask

   task automatic clr_obs();
      obs_addr = '0; obs_we = 0; obs_wdata = '0;
      memreq_cycles = 0; prg_acks = 0; chr_acks = 0;
      prg_ack_cyc = 0; chr_ack_cyc = 0;
      ack_log.delete();
   endtask

   task automatic drive_clients();
      if (prg_active && prg_ack_o) begin
         prg_active = 0; prg_req_i = 1'b0;
      end else if (!prg_active && q_prg.size() > 0) begin
         if (prg_wait < q_prg[0].gap) prg_wait++;
         else begin
            cur_prg = q_prg.pop_front(); prg_wait = 0; prg_active = 1;
            prg_we_i = cur_prg.we; prg_sel_ram_i = cur_prg.sel_ram;
            prg_rom_addr_i = cur_prg.addr; prg_ram_addr_i = cur_prg.addr[14:0];
            prg_wdata_i = cur_prg.wdata; prg_req_i = 1'b1; prg_raise_cyc = cyc;
         end
      end
      if (chr_active && chr_ack_o) begin
         chr_active = 0; chr_req_i = 1'b0;
      end else if (!chr_active && q_chr.size() > 0) begin
         if (chr_wait < q_chr[0].gap) chr_wait++;
         else begin
            cur_chr = q_chr.pop_front(); chr_wait = 0; chr_active = 1;
            chr_we_i = cur_chr.we; chr_addr_i = cur_chr.addr[17:0];
            chr_wdata_i = cur_chr.wdata; chr_req_i = 1'b1; chr_raise_cyc = cyc;
         end
      end
   endtask

   // Memory responder: acks after mem_lat waiting cycles; optional stray acks
   // while no request is outstanding.
   task automatic drive_memory();
      if (mem_req_o) begin
         if (mem_cnt >= mem_lat) begin
            mem_ack_i = 1'b1;
            if (mem_we_o) begin
               tb_mem[int'(mem_addr_o)] = mem_wdata_o;
               mem_rdata_i = 8'($urandom);
            end else begin
               mem_rdata_i = tb_rd(int'(mem_addr_o));
            end
            mem_cnt = 0;
            mem_lat = lat_random ? int'($urandom_range(0, 3)) : fixed_lat;
         end else begin
            mem_ack_i = 1'b0; mem_cnt++; mem_rdata_i = 8'($urandom);
         end
      end else begin
         mem_cnt = 0;
         mem_ack_i = spurious_en && ($urandom_range(0, 3) == 0);
         mem_rdata_i = 8'($urandom);
      end
   endtask

   // Advance the reference model using the inputs the DUT will sample next.
   task automatic model_step();
      bit pick, dropped;
      op_t o;
      if (!rst_n) begin
         model_reset();
      end else if (m_ack_now) begin
         m_last = m_owner; m_ack_now = 0;
      end else if (m_in_mem) begin
         if (mem_ack_i) begin
            m_in_mem = 0; m_ack_now = 1;
            if (m_we) ref_mem[int'(m_addr)] = m_wdata;
            else if (m_owner) e_chr_rdata = ref_rd(int'(m_addr));
            else e_prg_rdata = ref_rd(int'(m_addr));
         end
      end else if (prg_req_i || chr_req_i) begin
         pick = (prg_req_i && chr_req_i) ? !m_last : chr_req_i;
         o = pick ? cur_chr : cur_prg;
         m_owner = pick; m_we = o.we; m_wdata = o.wdata;
         m_addr = exp_addr(pick, o);
         dropped = pick ? o.we : (o.we && !o.sel_ram);
         if (dropped) m_ack_now = 1;
         else m_in_mem = 1;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      cyc++;
      chk("mem_req", 32'(mem_req_o), 32'(m_in_mem));
      chk("prg_ack", 32'(prg_ack_o), 32'(m_ack_now && !m_owner));
      chk("chr_ack", 32'(chr_ack_o), 32'(m_ack_now && m_owner));
      chk("prg_rdata", 32'(prg_rdata_o), 32'(e_prg_rdata));
      chk("chr_rdata", 32'(chr_rdata_o), 32'(e_chr_rdata));
      if (m_in_mem) begin
         chk("mem_addr", 32'(mem_addr_o), 32'(m_addr));
         chk("mem_we", 32'(mem_we_o), 32'(m_we));
         if (m_we) chk("mem_wdata", 32'(mem_wdata_o), 32'(m_wdata));
      end
      if (mem_req_o) begin
         memreq_cycles++;
         if (!obs_prev_req) begin
            obs_addr = mem_addr_o; obs_we = mem_we_o; obs_wdata = mem_wdata_o;
         end
      end
      obs_prev_req = mem_req_o;
      if (prg_ack_o) begin prg_acks++; prg_ack_cyc = cyc; ack_log.push_back(1'b0); end
      if (chr_ack_o) begin chr_acks++; chr_ack_cyc = cyc; ack_log.push_back(1'b1); end
      drive_clients();
      drive_memory();
      model_step();
   endtask

   task automatic run_idle(input string name, input int budget);
      int  n;
      bit  busy;
      n = 0;
      busy = 1;
      while (busy && n < budget) begin
         cycle();
         n++;
         busy = (q_prg.size() > 0) || (q_chr.size() > 0) || prg_active || chr_active
                || m_in_mem || m_ack_now;
      end
      chk({"timeout_", name}, 32'(busy), 32'(0));
      cycle();
      cycle();
   endtask

   initial begin
      model_reset();
      clr_obs();
      obs_prev_req = 0;
      mem_lat = 0;

      // Reset state
      repeat (3) cycle();
      chk("reset_mem_req", 32'(mem_req_o), 0);
      chk("reset_mem_addr", 32'(mem_addr_o), 0);
      chk("reset_mem_we", 32'(mem_we_o), 0);
      chk("reset_mem_wdata", 32'(mem_wdata_o), 0);
      chk("reset_prg_ack", 32'(prg_ack_o), 0);
      chk("reset_chr_ack", 32'(chr_ack_o), 0);
      chk("reset_prg_rdata", 32'(prg_rdata_o), 0);
      chk("reset_chr_rdata", 32'(chr_rdata_o), 0);
      rst_n = 1'b1;
      cycle();

      // Simultaneous requests from both clients, two reads each
      fixed_lat = 1; mem_lat = 1;
      clr_obs();
      q_chr.push_back(mk_op(0, 0, 19'h00100, 8'h00, 0));
      q_chr.push_back(mk_op(0, 0, 19'h00101, 8'h00, 0));
      q_prg.push_back(mk_op(0, 0, 19'h00200, 8'h00, 0));
      q_prg.push_back(mk_op(0, 1, 19'h00201, 8'h00, 0));
      run_idle("rr", 200);
      chk("rr_count", 32'(ack_log.size()), 4);
      if (ack_log.size() == 4)
         for (int i = 0; i < 4; i++) chk("rr_order", 32'(ack_log[i]), 32'(exp4[i]));

      // PRG ROM read, memory acks in the third MEM cycle
      tb_mem[32'h12345] = 8'hA5; ref_mem[32'h12345] = 8'hA5;
      fixed_lat = 2; mem_lat = 2;
      clr_obs();
      q_prg.push_back(mk_op(0, 0, 19'h12345, 8'h00, 0));
      run_idle("rom_read", 100);
      chk("rom_read_addr", 32'(obs_addr), 32'h12345);
      chk("rom_read_we", 32'(obs_we), 0);
      chk("rom_read_acks", 32'(prg_acks), 1);
      chk("rom_read_chr_acks", 32'(chr_acks), 0);
      chk("rom_read_rdata", 32'(prg_rdata_o), 32'hA5);
      chk("rom_read_latency", 32'(prg_ack_cyc - prg_raise_cyc), 4);

      // PRG RAM write, immediate memory ack
      fixed_lat = 0; mem_lat = 0;
      clr_obs();
      q_prg.push_back(mk_op(1, 1, 19'h00010, 8'h3C, 0));
      run_idle("ram_write", 100);
      chk("ram_write_addr", 32'(obs_addr), 32'hC0010);
      chk("ram_write_we", 32'(obs_we), 1);
      chk("ram_write_wdata", 32'(obs_wdata), 32'h3C);
      chk("ram_write_acks", 32'(prg_acks), 1);
      chk("ram_write_rdata_held", 32'(prg_rdata_o), 32'hA5);
      chk("ram_write_latency", 32'(prg_ack_cyc - prg_raise_cyc), 2);

      // CHR write with CHR as ROM: dropped, fast ack
      clr_obs();
      q_chr.push_back(mk_op(1, 0, 19'h01FFF, 8'h77, 0));
      run_idle("chr_drop", 100);
      chk("chr_drop_memreq", 32'(memreq_cycles), 0);
      chk("chr_drop_acks", 32'(chr_acks), 1);
      chk("chr_drop_latency", 32'(chr_ack_cyc - chr_raise_cyc), 1);

      // CHR read at the top of the CHR window
      tb_mem[32'hBFFFF] = 8'h5E; ref_mem[32'hBFFFF] = 8'h5E;
      clr_obs();
      q_chr.push_back(mk_op(0, 0, 19'h3FFFF, 8'h00, 0));
      run_idle("chr_top", 100);
      chk("chr_top_addr", 32'(obs_addr), 32'hBFFFF);
      chk("chr_top_rdata", 32'(chr_rdata_o), 32'h5E);

      // Reset while a read waits in MEM
      tb_mem[32'h00077] = 8'hC3; ref_mem[32'h00077] = 8'hC3;
      fixed_lat = 6; mem_lat = 6;
      clr_obs();
      q_prg.push_back(mk_op(0, 0, 19'h00077, 8'h00, 0));
      begin
         int n;
         n = 0;
         while (!mem_req_o && n < 20) begin cycle(); n++; end
         chk("rst_reach_mem", 32'(mem_req_o), 1);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_mem_req", 32'(mem_req_o), 0);
      chk("rst_async_prg_ack", 32'(prg_ack_o), 0);
      model_reset();
      q_prg.delete(); q_chr.delete();
      prg_active = 0; chr_active = 0; prg_wait = 0; chr_wait = 0;
      prg_req_i = 1'b0; chr_req_i = 1'b0; mem_ack_i = 1'b0; mem_cnt = 0;
      fixed_lat = 1; mem_lat = 1;
      repeat (3) cycle();
      chk("rst_no_ack", 32'(prg_acks + chr_acks), 0);
      rst_n = 1'b1;
      cycle();
      q_prg.push_back(mk_op(0, 0, 19'h00077, 8'h00, 0));
      run_idle("post_rst", 100);
      chk("post_rst_acks", 32'(prg_acks), 1);
      chk("post_rst_rdata", 32'(prg_rdata_o), 32'hC3);

      // Randomized traffic from both clients
      lat_random = 1; spurious_en = 1;
      for (int i = 0; i < 80; i++) begin
         logic [18:0] a;
         a = ($urandom_range(0, 1) == 0) ? 19'($urandom) : 19'($urandom_range(0, 15));
         q_prg.push_back(mk_op($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a,
                               8'($urandom), int'($urandom_range(0, 3))));
         a = ($urandom_range(0, 1) == 0) ? 19'($urandom) : 19'($urandom_range(0, 15));
         q_chr.push_back(mk_op($urandom_range(0, 3) == 0, 1'b0, a,
                               8'($urandom), int'($urandom_range(0, 3))));
      end
      run_idle("random", 5000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
